// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//
// Control unit for a five-stage pipeline (IF, ID, EX, MA, WB). It produces
// per-stage enables, IF/ID flush strobes and an EX bubble request. These
// outputs respond to branch, halt, load-use and external memory stall events.
//
// Optional feature macro: PIPE_CTRL_PERF_EN
//   defined   -> cycle_cnt / stall_cnt performance counters are implemented
//   undefined -> both counters are tied to zero and no counter flops exist
//
// Parameters
//   FLUSH_CYCLES  cycles IF/ID are flushed after a taken branch (1..15)
//   DRAIN_CYCLES  cycles MA/WB stay enabled after a halt (0..15)
//   CNT_W         width of the performance counters
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   start            leave IDLE and begin execution
//   halt_in          EX holds a HLT instruction
//   branch_taken_in  latched branch-taken from EX
//   ext_stall_in     memory not ready, freeze the whole pipe
//   load_use_in      ID reads a register being loaded in EX
//   resume           leave HALT once draining has finished
//   en_if..en_wb     per-stage enables (combinational)
//   flush_if/id      squash IF/ID latches (combinational)
//   bubble_ex        inject a NOP into EX (combinational)
//   halted           drain complete (registered)
//   state_out        current state encoding (registered)
//   cycle_cnt        non-IDLE cycle counter
//   stall_cnt        front-end stall cycle counter
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_in,
    input  logic             branch_taken_in,
    input  logic             ext_stall_in,
    input  logic             load_use_in,
    input  logic             resume,
    output logic             en_if,
    output logic             en_id,
    output logic             en_ex,
    output logic             en_ma,
    output logic             en_wb,
    output logic             flush_if,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic             halted,
    output logic [2:0]       state_out,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        FLUSH = 3'd2,
        STALL = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       halted_q;

    // State, down-counter and halted flag. halted is computed from the
    // next-state values so that it is a clean Moore output aligned with
    // state_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= (state_d == HALT) && (cnt_d == 4'd0);
        end
    end

    // Next-state and combinational stage control. In RUN, events resolve
    // in priority order halt > branch > external stall > load-use. In FLUSH,
    // an external stall freezes the pipe and the counter. The flush strobes
    // stay asserted while the pipe is frozen.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        en_if     = 1'b0;
        en_id     = 1'b0;
        en_ex     = 1'b0;
        en_ma     = 1'b0;
        en_wb     = 1'b0;
        flush_if  = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (start) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                en_if = 1'b1;
                en_id = 1'b1;
                en_ex = 1'b1;
                en_ma = 1'b1;
                en_wb = 1'b1;
                if (halt_in) begin
                    en_if   = 1'b0;
                    en_id   = 1'b0;
                    en_ex   = 1'b0;
                    state_d = HALT;
                    cnt_d   = DRAIN_INIT;
                end else if (branch_taken_in) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_INIT;
                end else if (ext_stall_in) begin
                    en_if   = 1'b0;
                    en_id   = 1'b0;
                    en_ex   = 1'b0;
                    en_ma   = 1'b0;
                    en_wb   = 1'b0;
                    state_d = STALL;
                end else if (load_use_in) begin
                    en_if     = 1'b0;
                    en_id     = 1'b0;
                    bubble_ex = 1'b1;
                end
            end

            STALL: begin
                if (!ext_stall_in) begin
                    en_if   = 1'b1;
                    en_id   = 1'b1;
                    en_ex   = 1'b1;
                    en_ma   = 1'b1;
                    en_wb   = 1'b1;
                    state_d = RUN;
                end
            end

            FLUSH: begin
                flush_if = 1'b1;
                flush_id = 1'b1;
                if (!ext_stall_in) begin
                    en_if = 1'b1;
                    en_id = 1'b1;
                    en_ex = 1'b1;
                    en_ma = 1'b1;
                    en_wb = 1'b1;
                    if (cnt_q <= 4'd1) begin
                        state_d = RUN;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end

            HALT: begin
                if (cnt_q != 4'd0) begin
                    en_ma = 1'b1;
                    en_wb = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end else if (resume) begin
                    state_d = RUN;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign state_out = state_q;
    assign halted    = halted_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_q, stall_q;

    // Saturating performance counters. A stall cycle is any active,
    // non-HALT cycle in which the front end (IF) is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            stall_q <= '0;
        end else begin
            if (state_q != IDLE && cycle_q != {CNT_W{1'b1}}) begin
                cycle_q <= cycle_q + 1'b1;
            end
            if (state_q != IDLE && state_q != HALT && !en_if &&
                stall_q != {CNT_W{1'b1}}) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign cycle_cnt = cycle_q;
    assign stall_cnt = stall_q;
`else
    assign cycle_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
//
// Directed testbench for pipe_ctrl with default parameters (FLUSH_CYCLES=2,
// DRAIN_CYCLES=2). Inputs change 1 ns after a rising edge. Outputs are
// checked 1 ns later, well away from the next edge.
// Counter expectations depend on whether PIPE_CTRL_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int CNT_W = 24;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             halt_in;
    logic             branch_taken_in;
    logic             ext_stall_in;
    logic             load_use_in;
    logic             resume;
    logic             en_if, en_id, en_ex, en_ma, en_wb;
    logic             flush_if, flush_id;
    logic             bubble_ex;
    logic             halted;
    logic [2:0]       state_out;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;

    int total;
    int bad;

    pipe_ctrl #(
        .FLUSH_CYCLES(2),
        .DRAIN_CYCLES(2),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt_in        (halt_in),
        .branch_taken_in(branch_taken_in),
        .ext_stall_in   (ext_stall_in),
        .load_use_in    (load_use_in),
        .resume         (resume),
        .en_if          (en_if),
        .en_id          (en_id),
        .en_ex          (en_ex),
        .en_ma          (en_ma),
        .en_wb          (en_wb),
        .flush_if       (flush_if),
        .flush_id       (flush_id),
        .bubble_ex      (bubble_ex),
        .halted         (halted),
        .state_out      (state_out),
        .cycle_cnt      (cycle_cnt),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle's worth of event inputs, then let them settle.
    task automatic applyStimulus(input logic st, input logic hlt, input logic br,
                                 input logic stl, input logic lu, input logic res);
        start           = st;
        halt_in         = hlt;
        branch_taken_in = br;
        ext_stall_in    = stl;
        load_use_in     = lu;
        resume          = res;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // en is {if,id,ex,ma,wb}; fl is {flush_if,flush_id}.
    task automatic checkAll(input string tag, input logic [2:0] st,
                            input logic [4:0] en, input logic [1:0] fl,
                            input logic bub, input logic hlt);
        checkOutput({tag, ".state"}, 32'(state_out), 32'(st));
        checkOutput({tag, ".en"}, 32'({en_if, en_id, en_ex, en_ma, en_wb}), 32'(en));
        checkOutput({tag, ".flush"}, 32'({flush_if, flush_id}), 32'(fl));
        checkOutput({tag, ".bubble"}, 32'(bubble_ex), 32'(bub));
        checkOutput({tag, ".halted"}, 32'(halted), 32'(hlt));
    endtask

    task automatic checkCounters(input string tag, input int cyc, input int stl);
`ifdef PIPE_CTRL_PERF_EN
        checkOutput({tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'(cyc));
        checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(stl));
`else
        checkOutput({tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'd0);
        checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt), 32'd0);
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        tick();
        checkAll("reset", 3'd0, 5'b00000, 2'b00, 1'b0, 1'b0);
        checkCounters("reset", 0, 0);
        tick();
        rst_n = 1'b1;

        // Stay in IDLE without start
        tick();
        checkAll("idle_hold", 3'd0, 5'b00000, 2'b00, 1'b0, 1'b0);

        // Start: IDLE outputs stay low in the start cycle, RUN next
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkAll("idle_start", 3'd0, 5'b00000, 2'b00, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkAll("run", 3'd1, 5'b11111, 2'b00, 1'b0, 1'b0);

        // Load-use bubble
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkAll("load_use", 3'd1, 5'b00111, 2'b00, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkAll("after_lu", 3'd1, 5'b11111, 2'b00, 1'b0, 1'b0);

        // Branch with load_use also asserted: branch wins, enables stay high
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkAll("branch", 3'd1, 5'b11111, 2'b00, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkAll("flush1", 3'd2, 5'b11111, 2'b11, 1'b0, 1'b0);
        tick();

        // Three stall cycles at cnt=1; halt_in is ignored in FLUSH
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            checkAll("flush_stall", 3'd2, 5'b00000, 2'b11, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkAll("flush_last", 3'd2, 5'b11111, 2'b11, 1'b0, 1'b0);
        tick();
        checkAll("flush_done", 3'd1, 5'b11111, 2'b00, 1'b0, 1'b0);
        checkCounters("after_flush", 7, 4);

        // External stall from RUN; start must be ignored outside IDLE
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkAll("run_stall", 3'd1, 5'b00000, 2'b00, 1'b0, 1'b0);
        tick();
        checkAll("stall_hold", 3'd3, 5'b00000, 2'b00, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkAll("stall_release", 3'd3, 5'b11111, 2'b00, 1'b0, 1'b0);
        tick();
        checkAll("stall_back", 3'd1, 5'b11111, 2'b00, 1'b0, 1'b0);

        // Halt outranks branch and stall; drain for two cycles
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkAll("halt", 3'd1, 5'b00011, 2'b00, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkAll("drain2", 3'd4, 5'b00011, 2'b00, 1'b0, 1'b0);
        tick();
        checkAll("drain1", 3'd4, 5'b00011, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkAll("halted", 3'd4, 5'b00000, 2'b00, 1'b0, 1'b1);
        tick();
        checkAll("halted_hold", 3'd4, 5'b00000, 2'b00, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkAll("resumed", 3'd1, 5'b11111, 2'b00, 1'b0, 1'b0);
        checkCounters("after_halt", 15, 7);

        // Asynchronous reset in the middle of a flush
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkAll("flush_again", 3'd2, 5'b11111, 2'b11, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        checkAll("async_reset", 3'd0, 5'b00000, 2'b00, 1'b0, 1'b0);
        checkCounters("async_reset", 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        checkAll("post_reset", 3'd0, 5'b00000, 2'b00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
